// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, responder FSM states and the mode constants
// used by both ends of the link.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W = 8;
   localparam int unsigned SPI_CNT_W  = 4;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_slv_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-wide TX/RX user handshake of the SPI responder.
interface spi_slave_if;
   import spi_pkg::*;

   logic                  sclk;
   logic                  mosi;
   logic                  cs_n;
   logic                  miso;
   logic [SPI_BYTE_W-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [SPI_BYTE_W-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;

   modport slave (
      input  sclk, mosi, cs_n, tx_data, tx_valid,
      output miso, tx_ready, rx_data, rx_valid, busy
   );

   modport master (
      output sclk, mosi, cs_n, tx_data, tx_valid,
      input  miso, tx_ready, rx_data, rx_valid, busy
   );

endinterface

// File: rtl/spi_sync.sv
// N-stage single-bit synchronizer with a configurable idle/reset level.
module spi_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages_q;

   always_ff @(posedge clk) begin
      if (rst) stages_q <= {SYNC_STAGES{RESET_VAL}};
      else     stages_q <= {stages_q[SYNC_STAGES-2:0], d};
   end

   assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled on clk (sclk <= clk/8).
// Define SPI_SLAVE_STATUS_EN to add sticky tx_underrun / rx_abort status flags.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned           SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
   input  logic          clk,
   input  logic          rst,
   spi_slave_if.slave    bus
`ifdef SPI_SLAVE_STATUS_EN
   ,
   input  logic          status_clr,
   output logic          tx_underrun,
   output logic          rx_abort
`endif
);

   localparam logic [SPI_CNT_W-1:0] BYTE_CNT = SPI_CNT_W'(SPI_BYTE_W);

   spi_slv_state_t        state_q, state_d;
   logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SPI_BYTE_W-1:0] tx_sh_q, tx_sh_d;
   logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic                  miso_q, miso_d;
   logic                  rx_done_q, rx_done_d;
   logic                  rx_valid_q;
   logic                  sclk_s, mosi_s, cs_n_s;
   logic                  sclk_d, cs_n_d;
   logic                  rise_c, fall_c, sel_c, desel_c, load_c;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
      .clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_n_s));

   assign rise_c  =  sclk_s & ~sclk_d;
   assign fall_c  = ~sclk_s &  sclk_d;
   assign sel_c   = ~cs_n_s &  cs_n_d;
   assign desel_c =  cs_n_s & ~cs_n_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         miso_q     <= 1'b0;
         rx_done_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         sclk_d     <= 1'b0;
         cs_n_d     <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         miso_q     <= miso_d;
         rx_done_q  <= rx_done_d;
         rx_valid_q <= rx_done_q;
         sclk_d     <= sclk_s;
         cs_n_d     <= cs_n_s;
      end
   end

   // Deselect outranks any sclk edge seen in the same cycle.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      miso_d    = miso_q;
      rx_done_d = 1'b0;
      load_c    = 1'b0;
      rx_data_d = rx_done_q ? rx_sh_q : rx_data_q;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (sel_c) begin
               state_d   = ACTIVE;
               bit_cnt_d = '0;
               load_c    = 1'b1;
            end
         end
         ACTIVE: begin
            if (desel_c) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               miso_d    = 1'b0;
            end else if (rise_c && (bit_cnt_q < BYTE_CNT)) begin
               rx_sh_d   = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
               bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
               rx_done_d = (bit_cnt_q == BYTE_CNT - SPI_CNT_W'(1));
            end else if (fall_c) begin
               if (bit_cnt_q == BYTE_CNT) begin
                  bit_cnt_d = '0;
                  load_c    = 1'b1;
               end else begin
                  tx_sh_d = {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
                  miso_d  = tx_sh_q[SPI_BYTE_W-2];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // First bit of a freshly loaded byte goes straight onto miso.
      if (load_c) begin
         tx_sh_d = bus.tx_valid ? bus.tx_data : DEFAULT_TX;
         miso_d  = tx_sh_d[SPI_BYTE_W-1];
      end
   end

   assign bus.miso     = miso_q;
   assign bus.tx_ready = load_c;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = (state_q == ACTIVE);

`ifdef SPI_SLAVE_STATUS_EN
   logic underrun_set_c, abort_set_c;

   assign underrun_set_c = load_c & ~bus.tx_valid;
   assign abort_set_c    = (state_q == ACTIVE) && desel_c &&
                           (bit_cnt_q != '0) && (bit_cnt_q < BYTE_CNT);

   // Sticky flags; a set event wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_underrun <= 1'b0;
         rx_abort    <= 1'b0;
      end else begin
         tx_underrun <= underrun_set_c | (tx_underrun & ~status_clr);
         rx_abort    <= abort_set_c    | (rx_abort    & ~status_clr);
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: vector table of single-byte transfers plus
// hand-written back-to-back, abort, reset and clk/8 streaming sequences.
module tb_spi_slave;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_slave_if bus ();

`ifdef SPI_SLAVE_STATUS_EN
   logic status_clr, tx_underrun, rx_abort;
`endif

   spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef SPI_SLAVE_STATUS_EN
      ,
      .status_clr  (status_clr),
      .tx_underrun (tx_underrun),
      .rx_abort    (rx_abort)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // TX feeder and RX/strobe monitor, all on the falling clk edge.
   logic [7:0] tx_q[$];
   logic [7:0] rx_got[$];
   int         rxv_cnt = 0;
   int         txr_cnt = 0;
   bit         pop_pend = 1'b0;

   always @(negedge clk) begin
      if (pop_pend && tx_q.size() > 0) void'(tx_q.pop_front());
      pop_pend = bus.tx_ready && bus.tx_valid;
      if (bus.tx_ready) txr_cnt++;
      if (bus.rx_valid) begin
         rxv_cnt++;
         rx_got.push_back(bus.rx_data);
      end
      bus.tx_valid = (tx_q.size() > 0);
      bus.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
   end

   // Mode-0 master: mosi set while sclk low, miso sampled just before the rise.
   task automatic master_bits(input logic [7:0] mo, input int nbits, input int half,
                              input bit last, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = mo[7-i];
         repeat (half) @(negedge clk);
         mi[7-i]  = bus.miso;
         bus.sclk = 1'b1;
         repeat (half) @(negedge clk);
         bus.sclk = 1'b0;
         if (last && i == nbits - 1) bus.cs_n = 1'b1;
      end
   endtask

   typedef struct {
      logic [7:0] mo;
      logic [7:0] tx;
      bit         tx_valid;
      int         half;
      logic [7:0] exp_mi;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t       vecs[5];
   logic [7:0] mi, mi2;
   logic [7:0] mo_bytes[64];
   logic [7:0] tx_bytes[64];
   int         r0, t0;

   initial begin
      vecs[0] = '{8'hA5, 8'h3C, 1'b1, 25, 8'h3C, 8'hA5};
      vecs[1] = '{8'h5A, 8'h00, 1'b0,  8, 8'hFF, 8'h5A};
      vecs[2] = '{8'h00, 8'hFF, 1'b1,  4, 8'hFF, 8'h00};
      vecs[3] = '{8'hFF, 8'h00, 1'b1,  4, 8'h00, 8'hFF};
      vecs[4] = '{8'h6E, 8'h91, 1'b1,  6, 8'h91, 8'h6E};

      rst      = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      bus.cs_n = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
      status_clr = 1'b0;
`endif
      repeat (4) @(negedge clk);
      check("rst_miso", 32'(bus.miso), 0);
      check("rst_tx_ready", 32'(bus.tx_ready), 0);
      check("rst_rx_valid", 32'(bus.rx_valid), 0);
      check("rst_rx_data", 32'(bus.rx_data), 0);
      check("rst_busy", 32'(bus.busy), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single-byte vectors
      for (int v = 0; v < 5; v++) begin
         r0 = rxv_cnt;
         t0 = txr_cnt;
         if (vecs[v].tx_valid) tx_q.push_back(vecs[v].tx);
         repeat (2) @(negedge clk);
         bus.cs_n = 1'b0;
         master_bits(vecs[v].mo, 8, vecs[v].half, 1'b1, mi);
         repeat (12) @(negedge clk);
         check($sformatf("vec%0d_master_rx", v), 32'(mi), 32'(vecs[v].exp_mi));
         check($sformatf("vec%0d_rx_data", v), 32'(bus.rx_data), 32'(vecs[v].exp_rx));
         check($sformatf("vec%0d_rx_valid_pulses", v), rxv_cnt - r0, 1);
         check($sformatf("vec%0d_tx_ready_pulses", v), txr_cnt - t0, 1);
         check($sformatf("vec%0d_busy_after", v), 32'(bus.busy), 0);
`ifdef SPI_SLAVE_STATUS_EN
         check($sformatf("vec%0d_tx_underrun", v), 32'(tx_underrun), vecs[v].tx_valid ? 0 : 1);
         status_clr = 1'b1;
         @(negedge clk);
         status_clr = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_underrun_clr", v), 32'(tx_underrun), 0);
`endif
      end

      // Back-to-back bytes, with miso latency after select
      r0 = rxv_cnt;
      t0 = txr_cnt;
      rx_got.delete();
      tx_q.push_back(8'hC3);
      tx_q.push_back(8'h5A);
      repeat (2) @(negedge clk);
      bus.cs_n = 1'b0;
      repeat (2) @(negedge clk);
      check("b2b_miso_before_latency", 32'(bus.miso), 0);
      @(negedge clk);
      check("b2b_miso_at_latency", 32'(bus.miso), 1);
      check("b2b_busy", 32'(bus.busy), 1);
      master_bits(8'h12, 8, 8, 1'b0, mi);
      master_bits(8'h34, 8, 8, 1'b1, mi2);
      repeat (12) @(negedge clk);
      check("b2b_master_rx0", 32'(mi), 32'h C3);
      check("b2b_master_rx1", 32'(mi2), 32'h5A);
      check("b2b_rx_valid_pulses", rxv_cnt - r0, 2);
      check("b2b_rx0", 32'(rx_got[0]), 32'h12);
      check("b2b_rx1", 32'(rx_got[1]), 32'h34);
      check("b2b_tx_ready_pulses", txr_cnt - t0, 2);

      // Abort after 5 rises
      r0 = rxv_cnt;
      tx_q.push_back(8'hAA);
      repeat (2) @(negedge clk);
      bus.cs_n = 1'b0;
      master_bits(8'hB7, 5, 8, 1'b0, mi);
      check("abort_busy_before", 32'(bus.busy), 1);
      bus.cs_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_no_rx_valid", rxv_cnt - r0, 0);
      check("abort_rx_data_held", 32'(bus.rx_data), 32'h34);
      check("abort_busy_after", 32'(bus.busy), 0);
`ifdef SPI_SLAVE_STATUS_EN
      check("abort_flag", 32'(rx_abort), 1);
      status_clr = 1'b1;
      @(negedge clk);
      status_clr = 1'b0;
      @(negedge clk);
      check("abort_flag_clr", 32'(rx_abort), 0);
`endif
      r0 = rxv_cnt;
      tx_q.push_back(8'h42);
      repeat (2) @(negedge clk);
      bus.cs_n = 1'b0;
      master_bits(8'h81, 8, 8, 1'b1, mi);
      repeat (12) @(negedge clk);
      check("post_abort_master_rx", 32'(mi), 32'h42);
      check("post_abort_rx_data", 32'(bus.rx_data), 32'h81);
      check("post_abort_rx_valid_pulses", rxv_cnt - r0, 1);

      // Reset after 3 bits
      tx_q.push_back(8'hE7);
      repeat (2) @(negedge clk);
      bus.cs_n = 1'b0;
      master_bits(8'hCC, 3, 8, 1'b0, mi);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_miso", 32'(bus.miso), 0);
      check("midrst_tx_ready", 32'(bus.tx_ready), 0);
      check("midrst_rx_valid", 32'(bus.rx_valid), 0);
      check("midrst_rx_data", 32'(bus.rx_data), 0);
      check("midrst_busy", 32'(bus.busy), 0);
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      r0 = rxv_cnt;
      tx_q.push_back(8'h1B);
      repeat (2) @(negedge clk);
      bus.cs_n = 1'b0;
      master_bits(8'hF0, 8, 8, 1'b1, mi);
      repeat (12) @(negedge clk);
      check("post_rst_master_rx", 32'(mi), 32'h1B);
      check("post_rst_rx_data", 32'(bus.rx_data), 32'hF0);
      check("post_rst_rx_valid_pulses", rxv_cnt - r0, 1);

      // 64 random bytes at sclk = clk/8 in one select window
      r0 = rxv_cnt;
      rx_got.delete();
      for (int i = 0; i < 64; i++) begin
         mo_bytes[i] = 8'($urandom);
         tx_bytes[i] = 8'($urandom);
         tx_q.push_back(tx_bytes[i]);
      end
      repeat (2) @(negedge clk);
      bus.cs_n = 1'b0;
      for (int i = 0; i < 64; i++) begin
         master_bits(mo_bytes[i], 8, 4, (i == 63), mi);
         check($sformatf("fast_master_rx%0d", i), 32'(mi), 32'(tx_bytes[i]));
      end
      repeat (12) @(negedge clk);
      check("fast_rx_valid_pulses", rxv_cnt - r0, 64);
      for (int i = 0; i < 64; i++)
         check($sformatf("fast_rx%0d", i), 32'(rx_got[i]), 32'(mo_bytes[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
